// File: rtl/multdiv_pkg.sv
// Shared types for the multdiv_param unit: FSM states, radix-4 Booth operations
// and the Booth recoding function.
package multdiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } stateT;

  typedef enum logic [2:0] {
    NOP,
    ADD1,
    ADD2,
    SUB1,
    SUB2
  } boothOpT;

  // Radix-4 recoding of {b[i+1], b[i], b[i-1]} into a multiple of the multiplicand.
  function automatic boothOpT boothDecode(input logic [2:0] bits);
    boothOpT op;
    case (bits)
      3'b001, 3'b010: op = ADD1;
      3'b011:         op = ADD2;
      3'b100:         op = SUB2;
      3'b101, 3'b110: op = SUB1;
      default:        op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface multdiv_if #(
  parameter int WIDTH = 32
);

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/multdiv_booth_step.sv
// One radix-4 Booth iteration: add/subtract {0, A, 2A} into the upper part of the
// running product, then arithmetic shift right by two.
module multdiv_booth_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] prodIn,
  input  logic             prevBit,
  input  logic [WIDTH-1:0] mcand,
  output logic [2*WIDTH:0] prodOut
);

  boothOpT          op;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] mcand1;
  logic [WIDTH+1:0] mcand2;
  logic [WIDTH+1:0] sum;

  // The sum is kept one bit wider than the accumulator because +-2*MIN can
  // briefly exceed WIDTH+1 signed bits before the shift brings it back in range.
  always_comb begin
    op     = boothDecode({prodIn[1:0], prevBit});
    acc    = {prodIn[2*WIDTH], prodIn[2*WIDTH:WIDTH]};
    mcand1 = {{2{mcand[WIDTH-1]}}, mcand};
    mcand2 = {mcand[WIDTH-1], mcand, 1'b0};
    case (op)
      ADD1:    sum = acc + mcand1;
      ADD2:    sum = acc + mcand2;
      SUB1:    sum = acc - mcand1;
      SUB2:    sum = acc - mcand2;
      default: sum = acc;
    endcase
    prodOut = {sum[WIDTH+1], sum, prodIn[WIDTH-1:2]};
  end

endmodule

// File: rtl/multdiv_param.sv
// Sequential signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Optional build macro MULTDIV_EARLY_OUT_EN finishes zero-operand cases after one step.
module multdiv_param
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  multdiv_if.slave bus
);

  localparam int CntW = $clog2(WIDTH) + 1;

`ifdef MULTDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  stateT            state;
  stateT            nextState;
  logic [2*WIDTH:0] prod;
  logic [2*WIDTH:0] boothNext;
  logic [2*WIDTH:0] divNext;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] quotMag;
  logic [WIDTH-1:0] quotSigned;
  logic [WIDTH-1:0] resultReg;
  logic [WIDTH:0]   divisorExt;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remNew;
  logic [WIDTH:0]   remFix;
  logic [WIDTH:0]   mulHigh;
  logic [CntW-1:0]  cnt;
  logic             prevBit;
  logic             negQuot;
  logic             divZero;
  logic             zeroOp;
  logic             excReg;
  logic             lastMul;
  logic             lastDiv;
  logic             earlyDone;
  logic             mulOvf;
  logic             divOvf;

  multdiv_booth_step #(.WIDTH(WIDTH)) boothStep (
    .prodIn  (prod),
    .prevBit (prevBit),
    .mcand   (mcand),
    .prodOut (boothNext)
  );

  assign absA = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign absB = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

  // Divider shares the product register: upper WIDTH+1 bits hold the partial
  // remainder, lower WIDTH bits shift the dividend out and the quotient in.
  assign divisorExt = {1'b0, mcand};
  assign remShift   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign remNew     = prod[2*WIDTH] ? (remShift + divisorExt) : (remShift - divisorExt);
  assign divNext    = {remNew, prod[WIDTH-2:0], ~remNew[WIDTH]};
  assign remFix     = prod[2*WIDTH] ? (prod[2*WIDTH:WIDTH] + divisorExt) : prod[2*WIDTH:WIDTH];
  assign quotMag    = prod[WIDTH-1:0];
  assign quotSigned = negQuot ? (~quotMag + 1'b1) : quotMag;
  assign divOvf     = ~negQuot & quotMag[WIDTH-1];

  assign mulHigh   = boothNext[2*WIDTH-1:WIDTH-1];
  assign mulOvf    = ~((&mulHigh) | ~(|mulHigh));
  assign lastMul   = (cnt == CntW'(WIDTH/2 - 1));
  assign lastDiv   = (cnt == CntW'(WIDTH - 1));
  assign earlyDone = EarlyOut & zeroOp;

  assign bus.data_result    = resultReg;
  assign bus.data_exception = excReg;
  assign bus.data_resultRDY = (state == DONE);

  // State register; a reset mid-operation drops the operation without a ready pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A new start pre-empts whatever is in flight, with multiply taking priority.
  always_comb begin
    nextState = state;
    if (bus.ctrl_MULT) begin
      nextState = MUL;
    end else if (bus.ctrl_DIV) begin
      nextState = DIV;
    end else begin
      case (state)
        MUL:     if (earlyDone || lastMul) nextState = DONE;
        DIV:     if (earlyDone) nextState = DONE;
                 else if (lastDiv) nextState = FIX;
        FIX:     nextState = DONE;
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and result/exception registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod      <= '0;
      mcand     <= '0;
      prevBit   <= 1'b0;
      cnt       <= '0;
      negQuot   <= 1'b0;
      divZero   <= 1'b0;
      zeroOp    <= 1'b0;
      resultReg <= '0;
      excReg    <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      mcand     <= bus.data_operandA;
      prod      <= {{(WIDTH+1){1'b0}}, bus.data_operandB};
      prevBit   <= 1'b0;
      cnt       <= '0;
      negQuot   <= 1'b0;
      divZero   <= 1'b0;
      zeroOp    <= (bus.data_operandA == '0) || (bus.data_operandB == '0);
      resultReg <= '0;
      excReg    <= 1'b0;
    end else if (bus.ctrl_DIV) begin
      mcand     <= absB;
      prod      <= {{(WIDTH+1){1'b0}}, absA};
      prevBit   <= 1'b0;
      cnt       <= '0;
      negQuot   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      divZero   <= (bus.data_operandB == '0);
      zeroOp    <= (bus.data_operandA == '0) || (bus.data_operandB == '0);
      resultReg <= '0;
      excReg    <= 1'b0;
    end else begin
      case (state)
        MUL: begin
          prod    <= boothNext;
          prevBit <= prod[1];
          cnt     <= cnt + 1'b1;
          if (!earlyDone && lastMul) begin
            resultReg <= boothNext[WIDTH-1:0];
            excReg    <= mulOvf;
          end
        end
        DIV: begin
          prod <= divNext;
          cnt  <= cnt + 1'b1;
          if (earlyDone) begin
            excReg <= divZero;
          end
        end
        FIX: begin
          prod      <= {remFix, prod[WIDTH-1:0]};
          resultReg <= divZero ? '0 : quotSigned;
          excReg    <= divZero | divOvf;
        end
        default: ;
      endcase
    end
  end

endmodule
